// File: rtl/match_sched_if.sv
// Requester/scheduler bundle for match_sched.
// The master side drives requests and data; the slave side is the scheduler.
interface match_sched_if #(
    parameter int N     = 4,
    parameter int CNT_W = 3,
    parameter int ID_W  = 2
) ();
    logic [N-1:0]     req;
    logic [N-1:0]     din;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             phase;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             abort;
    logic [ID_W-1:0]  done_id;

    modport master (
        output req, din,
        input  gnt, busy, phase, cnt, done, abort, done_id
    );

    modport slave (
        input  req, din,
        output gnt, busy, phase, cnt, done, abort, done_id
    );
endinterface

// File: rtl/match_sched.sv
// Round-robin scheduler sharing one phase-matching streak counter among N requesters.
// Optional macro MATCH_SCHED_RETRY_EN: tolerate up to 3 mismatches per run.
module match_sched #(
    parameter int N      = 4,
    parameter int CNT_W  = 3,
    parameter int TARGET = 5,
    parameter int ID_W   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    match_sched_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [N-1:0]     gnt_q, gnt_n;
    logic             phase_q;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             done_q, done_n;
    logic             abort_q, abort_n;
    logic [ID_W-1:0]  id_q, id_n;
    logic [ID_W-1:0]  ptr_q, ptr_n;
    logic [ID_W-1:0]  w_q, w_n;
    logic [ID_W-1:0]  win;
    logic             found;
    int               idx;
`ifdef MATCH_SCHED_RETRY_EN
    logic [1:0]       retry_q, retry_n;
`endif

    // First set request at or after the round-robin pointer
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && bus.req[idx]) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        logic leave;
        state_n = state;
        gnt_n   = gnt_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        abort_n = 1'b0;
        id_n    = id_q;
        ptr_n   = ptr_q;
        w_n     = w_q;
        leave   = 1'b0;
`ifdef MATCH_SCHED_RETRY_EN
        retry_n = retry_q;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_n   = N'(1) << win;
                    w_n     = win;
                    cnt_n   = '0;
                    state_n = RUN;
`ifdef MATCH_SCHED_RETRY_EN
                    retry_n = 2'd0;
`endif
                end
            end
            RUN: begin
                if (!bus.req[w_q]) begin
                    abort_n = 1'b1;
                    leave   = 1'b1;
                end else if (bus.din[w_q] != phase_q) begin
                    cnt_n = '0;
`ifdef MATCH_SCHED_RETRY_EN
                    if (retry_q != 2'd3) begin
                        retry_n = retry_q + 2'd1;
                    end else begin
                        abort_n = 1'b1;
                        leave   = 1'b1;
                    end
`else
                    abort_n = 1'b1;
                    leave   = 1'b1;
`endif
                end else if (cnt_q == CNT_W'(TARGET - 1)) begin
                    done_n = 1'b1;
                    cnt_n  = CNT_W'(TARGET);
                    leave  = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
                if (leave) begin
                    gnt_n   = '0;
                    id_n    = w_q;
                    ptr_n   = (w_q == ID_W'(N - 1)) ? '0 : w_q + ID_W'(1);
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_q   <= '0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
            w_q     <= '0;
        end else begin
            state   <= state_n;
            gnt_q   <= gnt_n;
            phase_q <= ~phase_q;
            cnt_q   <= cnt_n;
            done_q  <= done_n;
            abort_q <= abort_n;
            id_q    <= id_n;
            ptr_q   <= ptr_n;
            w_q     <= w_n;
        end
    end

`ifdef MATCH_SCHED_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retry_q <= 2'd0;
        else        retry_q <= retry_n;
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state == RUN);
    assign bus.phase   = phase_q;
    assign bus.cnt     = cnt_q;
    assign bus.done    = done_q;
    assign bus.abort   = abort_q;
    assign bus.done_id = id_q;
endmodule

// File: tb/tb_match_sched.sv
// Directed bench for match_sched (N=4, TARGET=5).
// Inputs change after the falling edge; outputs are checked on the falling edge.
module tb_match_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ph = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    match_sched_if #(.N(4), .CNT_W(3), .ID_W(2)) bus ();

    match_sched #(.N(4), .CNT_W(3), .TARGET(5), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive req, din = phase model xor mis, then land on the falling edge
    task automatic cyc(input logic [3:0] r, input logic [3:0] mis);
        bus.req = r;
        bus.din = {4{ph}} ^ mis;
        @(posedge clk);
        ph = ~ph;
        @(negedge clk);
    endtask

    initial begin
        bus.req = '0;
        bus.din = '0;
        #11;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_phase", bus.phase, 0);
        chk("rst_cnt", bus.cnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_abort", bus.abort, 0);
        chk("rst_id", bus.done_id, 0);
        #1 rst_n = 1'b1;

        // Single success on requester 0
        cyc(4'b0001, 4'b0000);
        chk("s1_gnt", bus.gnt, 4'b0001);
        chk("s1_busy", bus.busy, 1);
        chk("s1_cnt0", bus.cnt, 0);
        chk("s1_phase", bus.phase, ph);
        for (int i = 1; i <= 4; i++) begin
            cyc(4'b0001, 4'b0000);
            chk("s1_cnt", bus.cnt, i);
            chk("s1_done_lo", bus.done, 0);
        end
        cyc(4'b0001, 4'b0000);
        chk("s1_done", bus.done, 1);
        chk("s1_abort", bus.abort, 0);
        chk("s1_id", bus.done_id, 0);
        chk("s1_cnt5", bus.cnt, 5);
        chk("s1_gnt0", bus.gnt, 0);
        chk("s1_busy0", bus.busy, 0);
        cyc(4'b0000, 4'b0000);
        chk("s1_pulse", bus.done, 0);
        chk("s1_hold", bus.cnt, 5);
        chk("s1_phase2", bus.phase, ph);

        // Mismatch on requester 1 after two matches
        cyc(4'b0010, 4'b0000);
        chk("s2_gnt", bus.gnt, 4'b0010);
        chk("s2_cnt0", bus.cnt, 0);
        cyc(4'b0010, 4'b0000);
        chk("s2_cnt1", bus.cnt, 1);
        cyc(4'b0010, 4'b0000);
        chk("s2_cnt2", bus.cnt, 2);
        cyc(4'b0010, 4'b0010);
`ifdef MATCH_SCHED_RETRY_EN
        chk("s2_retry_cnt", bus.cnt, 0);
        chk("s2_retry_gnt", bus.gnt, 4'b0010);
        chk("s2_retry_abort", bus.abort, 0);
        cyc(4'b0010, 4'b0010);
        cyc(4'b0010, 4'b0010);
        chk("s2_retry_busy", bus.busy, 1);
        cyc(4'b0010, 4'b0010);
`endif
        chk("s2_abort", bus.abort, 1);
        chk("s2_done", bus.done, 0);
        chk("s2_id", bus.done_id, 1);
        chk("s2_cnt", bus.cnt, 0);
        chk("s2_gnt0", bus.gnt, 0);
        cyc(4'b0000, 4'b0000);
        chk("s2_pulse", bus.abort, 0);

        // Reset between runs brings ptr back to 0
        rst_n = 1'b0;
        ph = 1'b0;
        #1 rst_n = 1'b1;

        // Round-robin with all requests held
        for (int r = 0; r < 5; r++) begin
            cyc(4'b1111, 4'b0000);
            chk("rr_gnt", bus.gnt, 32'(4'b0001 << (r % 4)));
            for (int i = 0; i < 4; i++) begin
                cyc(4'b1111, 4'b0000);
                chk("rr_hold", bus.gnt, 32'(4'b0001 << (r % 4)));
            end
            cyc(4'b1111, 4'b0000);
            chk("rr_done", bus.done, 1);
            chk("rr_id", bus.done_id, r % 4);
            chk("rr_gap", bus.gnt, 0);
        end

        // Request drop on the would-be final match (ptr is now 1)
        cyc(4'b0010, 4'b0000);
        chk("s4_gnt", bus.gnt, 4'b0010);
        for (int i = 0; i < 4; i++) cyc(4'b0010, 4'b0000);
        chk("s4_cnt4", bus.cnt, 4);
        cyc(4'b0000, 4'b0000);
        chk("s4_abort", bus.abort, 1);
        chk("s4_done", bus.done, 0);
        chk("s4_id", bus.done_id, 1);
        chk("s4_gnt0", bus.gnt, 0);

        // Reset mid-run at cnt=3 (ptr is 2 before reset)
        cyc(4'b1000, 4'b0000);
        chk("s5_gnt", bus.gnt, 4'b1000);
        for (int i = 0; i < 3; i++) cyc(4'b1000, 4'b0000);
        chk("s5_cnt3", bus.cnt, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_gnt0", bus.gnt, 0);
        chk("s5_cnt0", bus.cnt, 0);
        chk("s5_phase", bus.phase, 0);
        chk("s5_busy", bus.busy, 0);
        chk("s5_done", bus.done, 0);
        chk("s5_abort", bus.abort, 0);
        @(posedge clk);
        @(negedge clk);
        chk("s5_hold_phase", bus.phase, 0);
        rst_n = 1'b1;
        ph = 1'b0;
        cyc(4'b1010, 4'b0000);
        chk("s5_ptr", bus.gnt, 4'b0010);
        cyc(4'b0000, 4'b0000);
        chk("s5_drop", bus.abort, 1);
        cyc(4'b0000, 4'b0000);

`ifdef MATCH_SCHED_RETRY_EN
        // Three mismatches absorbed, then five matches finish the run
        cyc(4'b0100, 4'b0000);
        chk("r_gnt", bus.gnt, 4'b0100);
        cyc(4'b0100, 4'b0000);
        chk("r_cnt1", bus.cnt, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100, 4'b0100);
            chk("r_mis_cnt", bus.cnt, 0);
            chk("r_mis_abort", bus.abort, 0);
        end
        for (int i = 1; i <= 4; i++) begin
            cyc(4'b0100, 4'b0000);
            chk("r_cnt", bus.cnt, i);
        end
        cyc(4'b0100, 4'b0000);
        chk("r_done", bus.done, 1);
        chk("r_id", bus.done_id, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
